// File: rtl/updn_counter.sv
// Parametrised synchronous up/down counter: load, enable, direction, wrap/saturate, TC, sticky OVF.
// Optional scan chain via `define RV523_COUNTER_SCAN_EN (adds i_se, i_si, o_so).
module updn_counter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic             i_ld,
  input  logic             i_up,
  input  logic             i_sat,
  input  logic [WIDTH-1:0] i_d,
`ifdef RV523_COUNTER_SCAN_EN
  input  logic             i_se,
  input  logic             i_si,
  output logic             o_so,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] RstQ = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] MaxQ = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_ovf;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_ovf_nxt;
  logic             w_bound;
  logic             w_scan;

`ifdef RV523_COUNTER_SCAN_EN
  assign w_scan = i_se;
  assign o_so   = r_q[WIDTH-1];
`else
  assign w_scan = 1'b0;
`endif

  // Boundary is detected by comparison; no carry beyond WIDTH is kept.
  assign w_bound = i_up ? (r_q == MaxQ) : (r_q == '0);

  always_comb begin
    w_q_nxt   = r_q;
    w_ovf_nxt = r_ovf;
    if (w_scan) begin
      w_q_nxt = {r_q[WIDTH-2:0], w_si()};
    end else if (i_ld) begin
      w_q_nxt   = i_d;
      w_ovf_nxt = 1'b0;
    end else if (i_en) begin
      if (w_bound) begin
        w_ovf_nxt = 1'b1;
        if (!i_sat) begin
          w_q_nxt = i_up ? '0 : MaxQ;
        end
      end else begin
        w_q_nxt = i_up ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_q   <= RstQ;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign o_q   = r_q;
  assign o_ovf = r_ovf;
  assign o_tc  = i_en & ~i_ld & ~w_scan & w_bound;

  function automatic logic w_si();
`ifdef RV523_COUNTER_SCAN_EN
    return i_si;
`else
    return 1'b0;
`endif
  endfunction

endmodule

// File: tb/tb_updn_counter.sv
// Self-checking bench for updn_counter (WIDTH=4, RST_VAL=0); expected Q/OVF go through a queue.
// Scan scenario runs only when RV523_COUNTER_SCAN_EN is defined.
module tb_updn_counter;

  logic       clk;
  logic       rstn;
  logic       en;
  logic       ld;
  logic       up;
  logic       sat;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc;
  logic       ovf;
`ifdef RV523_COUNTER_SCAN_EN
  logic       se;
  logic       si;
  logic       so;
`endif

  typedef struct {
    logic [3:0] q;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks;
  int   failures;

  updn_counter #(
    .WIDTH  (4),
    .RST_VAL(0)
  ) u_dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .i_en  (en),
    .i_ld  (ld),
    .i_up  (up),
    .i_sat (sat),
    .i_d   (d),
`ifdef RV523_COUNTER_SCAN_EN
    .i_se  (se),
    .i_si  (si),
    .o_so  (so),
`endif
    .o_q   (q),
    .o_tc  (tc),
    .o_ovf (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1; ld = 1'b1; up = 1'b1; sat = 1'b0; d = 4'd9;
    sb.push_back('{q: 4'd0, ovf: 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (q !== e.q || ovf !== e.ovf) begin
      failures++;
      $display("FAIL reset: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
    end
    rstn = 1'b1; ld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      sb.push_back('{q: 4'(i), ovf: 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ovf !== e.ovf) begin
        failures++;
        $display("FAIL reset_count: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
      end
    end
  endtask

  task automatic test_wrap_up();
    ld = 1'b1; en = 1'b0; d = 4'd14;
    sb.push_back('{q: 4'd14, ovf: 1'b0});
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0;
    #1;
    e = sb.pop_front();
    checks++;
    if (q !== e.q || ovf !== e.ovf || tc !== 1'b0) begin
      failures++;
      $display("FAIL wrap_load14: q=%0d ovf=%b tc=%b expected q=%0d ovf=%b tc=0",
               q, ovf, tc, e.q, e.ovf);
    end
    sb.push_back('{q: 4'd15, ovf: 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (q !== e.q || ovf !== e.ovf || tc !== 1'b1) begin
      failures++;
      $display("FAIL wrap_at15: q=%0d ovf=%b tc=%b expected q=%0d ovf=%b tc=1",
               q, ovf, tc, e.q, e.ovf);
    end
    sb.push_back('{q: 4'd0, ovf: 1'b1});
    sb.push_back('{q: 4'd1, ovf: 1'b1});
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ovf !== e.ovf) begin
        failures++;
        $display("FAIL wrap_over: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
      end
    end
  endtask

  task automatic test_sat_down();
    ld = 1'b1; en = 1'b0; d = 4'd1;
    sb.push_back('{q: 4'd1, ovf: 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (q !== e.q || ovf !== e.ovf) begin
      failures++;
      $display("FAIL sat_load: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
    end
    ld = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b1;
    sb.push_back('{q: 4'd0, ovf: 1'b0});
    sb.push_back('{q: 4'd0, ovf: 1'b1});
    sb.push_back('{q: 4'd0, ovf: 1'b1});
    for (int i = 0; i < 3; i++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ovf !== e.ovf || tc !== 1'b1) begin
        failures++;
        $display("FAIL sat_down: q=%0d ovf=%b tc=%b expected q=%0d ovf=%b tc=1",
                 q, ovf, tc, e.q, e.ovf);
      end
    end
  endtask

  task automatic test_load_vs_boundary();
    ld = 1'b1; en = 1'b0; d = 4'd15;
    sb.push_back('{q: 4'd15, ovf: 1'b0});
    tick();
    void'(sb.pop_front());
    en = 1'b1; up = 1'b1; sat = 1'b0; ld = 1'b1; d = 4'd5;
    #1;
    checks++;
    if (tc !== 1'b0) begin
      failures++;
      $display("FAIL load_tc: tc=%b expected 0", tc);
    end
    sb.push_back('{q: 4'd5, ovf: 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (q !== e.q || ovf !== e.ovf) begin
      failures++;
      $display("FAIL load_boundary: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
    end
  endtask

  task automatic test_hold_reset();
    ld = 1'b1; en = 1'b0; d = 4'd0;
    tick();
    // Underflow wrap sets OVF; then hold must keep both Q and OVF.
    ld = 1'b0; en = 1'b1; up = 1'b0; sat = 1'b0;
    sb.push_back('{q: 4'd15, ovf: 1'b1});
    tick();
    en = 1'b0;
    sb.push_back('{q: 4'd15, ovf: 1'b1});
    tick();
    for (int i = 0; i < 2; i++) begin
      e = sb.pop_front();
    end
    checks++;
    if (q !== e.q || ovf !== e.ovf) begin
      failures++;
      $display("FAIL hold_ovf: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
    end
    ld = 1'b1; d = 4'd0;
    tick();
    ld = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      sb.push_back('{q: 4'(i), ovf: 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ovf !== e.ovf) begin
        failures++;
        $display("FAIL count_to7: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{q: 4'd7, ovf: 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ovf !== e.ovf) begin
        failures++;
        $display("FAIL hold7: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
      end
    end
    rstn = 1'b0; en = 1'b1;
    sb.push_back('{q: 4'd0, ovf: 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (q !== e.q || ovf !== e.ovf) begin
      failures++;
      $display("FAIL mid_reset: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
    end
    rstn = 1'b1; en = 1'b0;
  endtask

  task automatic test_random();
    int mq;
    int mov;
    int mtc;
    mq  = int'(q);
    mov = int'(ovf);
    for (int i = 0; i < 300; i++) begin
      rstn = ($urandom_range(0, 19) != 0);
      ld   = ($urandom_range(0, 7) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = 1'($urandom_range(0, 1));
      sat  = 1'($urandom_range(0, 1));
      d    = 4'($urandom_range(0, 15));
      #1;
      mtc = (en && !ld && (up ? (mq == 15) : (mq == 0))) ? 1 : 0;
      checks++;
      if (tc !== 1'(mtc)) begin
        failures++;
        $display("FAIL rand_tc[%0d]: tc=%b expected %0d (q=%0d)", i, tc, mtc, mq);
      end
      if (!rstn) begin
        mq = 0; mov = 0;
      end else if (ld) begin
        mq = int'(d); mov = 0;
      end else if (en) begin
        if (up && mq == 15) begin
          mov = 1; mq = sat ? 15 : 0;
        end else if (!up && mq == 0) begin
          mov = 1; mq = sat ? 0 : 15;
        end else begin
          mq = up ? mq + 1 : mq - 1;
        end
      end
      sb.push_back('{q: 4'(mq), ovf: 1'(mov)});
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ovf !== e.ovf) begin
        failures++;
        $display("FAIL rand[%0d]: q=%0d ovf=%b expected q=%0d ovf=%b", i, q, ovf, e.q, e.ovf);
      end
    end
    rstn = 1'b1; ld = 1'b0; en = 1'b0;
  endtask

`ifdef RV523_COUNTER_SCAN_EN
  task automatic test_scan();
    logic [3:0] bits;
    logic [3:0] exp_q;
    bits  = 4'b1011;
    exp_q = 4'd0;
    rstn = 1'b0; se = 1'b0;
    tick();
    rstn = 1'b1; se = 1'b1; en = 1'b1; ld = 1'b1; up = 1'b1; d = 4'd9;
    for (int i = 3; i >= 0; i--) begin
      si    = bits[i];
      exp_q = {exp_q[2:0], bits[i]};
      sb.push_back('{q: exp_q, ovf: 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if (q !== e.q || ovf !== e.ovf) begin
        failures++;
        $display("FAIL scan_shift: q=%b ovf=%b expected q=%b ovf=%b", q, ovf, e.q, e.ovf);
      end
    end
    checks++;
    if (so !== 1'b1 || tc !== 1'b0) begin
      failures++;
      $display("FAIL scan_so_tc: so=%b tc=%b expected so=1 tc=0", so, tc);
    end
    se = 1'b0; ld = 1'b0;
    sb.push_back('{q: 4'd12, ovf: 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if (q !== e.q || ovf !== e.ovf) begin
      failures++;
      $display("FAIL scan_resume: q=%0d ovf=%b expected q=%0d ovf=%b", q, ovf, e.q, e.ovf);
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rstn = 1'b0; en = 1'b0; ld = 1'b0; up = 1'b0; sat = 1'b0; d = 4'd0;
`ifdef RV523_COUNTER_SCAN_EN
    se = 1'b0; si = 1'b0;
`endif
    tick();
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_load_vs_boundary();
    test_hold_reset();
    test_random();
`ifdef RV523_COUNTER_SCAN_EN
    test_scan();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
